atmega_eep_xfer: RTL

Host-side initiator for the ATmega EEPROM external access port (ext_eep_* signals).
- Dump: reads the whole EEPROM image out as a byte stream for saving to SD.
- Load: writes a byte stream from the host loader into the EEPROM.
- Sits between the MiSTer ioctl/save glue and the EEPROM peripheral. Holds ext_eep_data_en, and asserts a lock output to the core, for the full transfer.

---
 rtl/atmega_eep_xfer_pkg.sv | 24 ++
 rtl/atmega_eep_xfer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/atmega_eep_xfer_pkg.sv
// Shared definitions for the ATmega EEPROM external-port transfer engine.
// The size defaults are also used when instantiating the EEPROM peripheral.
package atmega_eep_xfer_pkg;

    localparam int EEP_SIZE_DEF = 512;
    localparam int ADDR_W_DEF   = 17;
    localparam int RD_LAT_DEF   = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DP_RD   = 3'd1,
        ST_DP_CAP  = 3'd2,
        ST_DP_OUT  = 3'd3,
        ST_LD_WAIT = 3'd4,
        ST_LD_WR   = 3'd5,
        ST_DONE    = 3'd6
    } xfer_state_t;

    // The external port is owned only while bytes are actually moving.
    function automatic logic owns_port(input xfer_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/atmega_eep_xfer.sv
// Dumps the whole EEPROM out as a byte stream, or loads it from one, through
// the ext_eep_* port while locking out CPU access for the duration.
module atmega_eep_xfer
    import atmega_eep_xfer_pkg::*;
#(
    parameter int EEP_SIZE = EEP_SIZE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_dump,
    input  logic              start_load,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              eep_lock,
    output logic [ADDR_W-1:0] ext_eep_addr,
    output logic [7:0]        ext_eep_data_in,
    output logic              ext_eep_data_wr,
    input  logic [7:0]        ext_eep_data_out,
    output logic              ext_eep_data_rd,
    output logic              ext_eep_data_en
);

    localparam int AW = (EEP_SIZE > 1) ? $clog2(EEP_SIZE) : 1;
    localparam int LW = $clog2(RD_LAT + 1);

    xfer_state_t   state_r;
    xfer_state_t   state_nxt_s;
    logic [AW-1:0] addr_r;
    logic [LW-1:0] lat_r;
    logic [7:0]    byte_r;
    logic [7:0]    out_data_r;
    logic          last_s;
    logic          lat_done_s;
    logic          start_s;
    logic          adv_s;

    assign last_s     = (addr_r == AW'(EEP_SIZE - 1));
    assign lat_done_s = (lat_r == LW'(RD_LAT - 1));
    assign start_s    = (state_r == ST_IDLE) && (start_dump || start_load);
    assign adv_s      = !abort && !last_s &&
                        (((state_r == ST_DP_OUT) && out_ready) || (state_r == ST_LD_WR));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks every handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_dump)      state_nxt_s = ST_DP_RD;
                else if (start_load) state_nxt_s = ST_LD_WAIT;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_DP_RD: begin
                if (abort)           state_nxt_s = ST_IDLE;
                else if (lat_done_s) state_nxt_s = ST_DP_CAP;
                else                 state_nxt_s = ST_DP_RD;
            end
            ST_DP_CAP: begin
                if (abort) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_DP_OUT;
            end
            ST_DP_OUT: begin
                if (abort)          state_nxt_s = ST_IDLE;
                else if (out_ready) state_nxt_s = last_s ? ST_DONE : ST_DP_RD;
                else                state_nxt_s = ST_DP_OUT;
            end
            ST_LD_WAIT: begin
                if (abort)         state_nxt_s = ST_IDLE;
                else if (in_valid) state_nxt_s = ST_LD_WR;
                else               state_nxt_s = ST_LD_WAIT;
            end
            ST_LD_WR: begin
                if (abort) state_nxt_s = ST_IDLE;
                else       state_nxt_s = last_s ? ST_DONE : ST_LD_WAIT;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Address, read-latency counter and the captured read/write bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= '0;
            lat_r      <= '0;
            byte_r     <= 8'h00;
            out_data_r <= 8'h00;
        end else begin
            lat_r <= (state_r == ST_DP_RD) ? lat_r + LW'(1) : '0;
            if (start_s) begin
                addr_r <= '0;
            end else if (adv_s) begin
                addr_r <= addr_r + AW'(1);
            end
            if (state_r == ST_DP_CAP) begin
                out_data_r <= ext_eep_data_out;
            end
            if ((state_r == ST_LD_WAIT) && in_valid && !abort) begin
                byte_r <= in_data;
            end
        end
    end

    // Strobes and handshakes decoded from state; a write already in LD_WR is not gated.
    always_comb begin
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        done            = 1'b0;
        ext_eep_data_rd = 1'b0;
        ext_eep_data_wr = 1'b0;
        case (state_r)
            ST_DP_RD:   ext_eep_data_rd = 1'b1;
            ST_DP_CAP:  ext_eep_data_rd = 1'b1;
            ST_DP_OUT:  out_valid       = !abort;
            ST_LD_WAIT: in_ready        = !abort;
            ST_LD_WR:   ext_eep_data_wr = 1'b1;
            ST_DONE:    done            = 1'b1;
            default:    done            = 1'b0;
        endcase
    end

    assign busy            = owns_port(state_r);
    assign ext_eep_data_en = busy;
    assign eep_lock        = busy;
    assign out_data        = out_data_r;
    assign ext_eep_addr    = ADDR_W'(addr_r);
    assign ext_eep_data_in = ext_eep_data_wr ? byte_r : 8'h00;

endmodule
